// File: rtl/ecpri_tx_resp_if.sv
// Request, RAM-port and status bundle between the eCPRI RX block, its RAMs and the RMA response builder.
interface ecpri_tx_resp_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                  send_read_resp;
  logic                  send_write_resp;
  logic [7:0]            resp_payload_len;
  logic [7:0]            rma_id;
  logic [15:0]           element_id;
  logic [15:0]           mem_addr;
  logic [ADDR_WIDTH-1:0] hdr_addr;
  logic                  hdr_oe;
  logic [DATA_WIDTH-1:0] hdr_data;
  logic [ADDR_WIDTH-1:0] pl_addr;
  logic                  pl_oe;
  logic [DATA_WIDTH-1:0] pl_data;
  logic [ADDR_WIDTH-1:0] tx_addr;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_we;
  logic [15:0]           tx_len;
  logic                  tx_start;
  logic                  busy;
  logic [7:0]            drop_cnt;

  modport master (
    output send_read_resp, send_write_resp, resp_payload_len, rma_id, element_id, mem_addr,
    output hdr_data, pl_data,
    input  hdr_addr, hdr_oe, pl_addr, pl_oe, tx_addr, tx_data, tx_we, tx_len, tx_start, busy,
    input  drop_cnt
  );

  modport slave (
    input  send_read_resp, send_write_resp, resp_payload_len, rma_id, element_id, mem_addr,
    input  hdr_data, pl_data,
    output hdr_addr, hdr_oe, pl_addr, pl_oe, tx_addr, tx_data, tx_we, tx_len, tx_start, busy,
    output drop_cnt
  );
endinterface

// File: rtl/ecpri_tx_resp.sv
// Builds an eCPRI RMA response frame byte by byte into the TX packet RAM, then pulses tx_start.
//   state     | meaning
//   S_IDLE    | waiting for a read/write response request
//   S_HDR     | bytes 0-13: MAC-swapped header from RX header RAM, then ethertype
//   S_ECPRI   | bytes 14-29: eCPRI common header and RMA response header
//   S_PAYLOAD | read data from payload RAM (read responses with L>0)
//   S_PAD     | zero padding up to MIN_FRAME bytes
//   S_DONE    | pipeline drain, then one-cycle tx_start
module ecpri_tx_resp #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] TX_BASE    = '0,
  parameter logic [ADDR_WIDTH-1:0] HDR_BASE   = '0,
  parameter int                    MIN_FRAME  = 60
) (
  input  logic           clk,
  input  logic           reset,
  ecpri_tx_resp_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_ECPRI, S_PAYLOAD, S_PAD, S_DONE} state_t;
  typedef enum logic [1:0] {SRC_CONST, SRC_HDR, SRC_PL} src_t;

  localparam logic [8:0]  LAST_PAD = 9'(MIN_FRAME - 1);
  localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME);

  state_t                state, state_nxt;
  logic [8:0]            n;
  logic [7:0]            rem, len_q, rma_q, drop_q;
  logic [15:0]           eid_q, addr_q, len_out, psize, frame_len;
  logic                  is_read;
  logic [ADDR_WIDTH-1:0] pl_ptr;
  logic [1:0]            drain;
  logic                  req_any, accept, drop_evt;
  logic [7:0]            ecpri_byte;

  logic                  s0_valid, s0_hdr_oe, s0_pl_oe;
  logic [ADDR_WIDTH-1:0] s0_hdr_addr, s0_pl_addr;
  src_t                  s0_src;
  logic [7:0]            s0_const;

  logic                  s1_valid, hdr_oe_q, pl_oe_q;
  logic [ADDR_WIDTH-1:0] hdr_addr_q, pl_addr_q;
  src_t                  s1_src;
  logic [7:0]            s1_const;
  logic [8:0]            s1_n;

  logic                  tx_we_q;
  logic [ADDR_WIDTH-1:0] tx_addr_q;
  src_t                  s2_src;
  logic [7:0]            s2_const;

  assign req_any   = bus.send_read_resp | bus.send_write_resp;
  assign accept    = (state == S_IDLE) && req_any;
  assign drop_evt  = ((state != S_IDLE) && req_any) ||
                     (accept && bus.send_read_resp && bus.send_write_resp);
  assign psize     = is_read ? 16'd12 + {8'd0, len_q} : 16'd12;
  assign frame_len = 16'd30 + {8'd0, bus.resp_payload_len};

  always_comb begin
    ecpri_byte = 8'h00;
    case (n)
      9'd14:   ecpri_byte = 8'h10;
      9'd15:   ecpri_byte = 8'h04;
      9'd16:   ecpri_byte = psize[15:8];
      9'd17:   ecpri_byte = psize[7:0];
      9'd18:   ecpri_byte = rma_q;
      9'd19:   ecpri_byte = is_read ? 8'h01 : 8'h11;
      9'd20:   ecpri_byte = eid_q[15:8];
      9'd21:   ecpri_byte = eid_q[7:0];
      9'd26:   ecpri_byte = addr_q[15:8];
      9'd27:   ecpri_byte = addr_q[7:0];
      9'd29:   ecpri_byte = len_q;
      default: ecpri_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    s0_valid    = 1'b0;
    s0_src      = SRC_CONST;
    s0_const    = 8'h00;
    s0_hdr_oe   = 1'b0;
    s0_hdr_addr = '0;
    s0_pl_oe    = 1'b0;
    s0_pl_addr  = '0;
    case (state)
      S_IDLE: if (req_any) state_nxt = S_HDR;
      S_HDR: begin
        s0_valid = 1'b1;
        if (n < 9'd12) begin
          // destination and source MAC trade places
          s0_hdr_oe   = 1'b1;
          s0_src      = SRC_HDR;
          s0_hdr_addr = HDR_BASE + ADDR_WIDTH'((n < 9'd6) ? n + 9'd6 : n - 9'd6);
        end else begin
          s0_const = (n == 9'd12) ? 8'hAE : 8'hFE;
        end
        if (n == 9'd13) state_nxt = S_ECPRI;
      end
      S_ECPRI: begin
        s0_valid = 1'b1;
        s0_const = ecpri_byte;
        if (n == 9'd29) begin
          if (is_read && (len_q != 8'd0)) state_nxt = S_PAYLOAD;
          else if (30 < MIN_FRAME)        state_nxt = S_PAD;
          else                            state_nxt = S_DONE;
        end
      end
      S_PAYLOAD: begin
        s0_valid   = 1'b1;
        s0_pl_oe   = 1'b1;
        s0_src     = SRC_PL;
        s0_pl_addr = pl_ptr;
        if (rem == 8'd0) state_nxt = (n < LAST_PAD) ? S_PAD : S_DONE;
      end
      S_PAD: begin
        s0_valid = 1'b1;
        if (n >= LAST_PAD) state_nxt = S_DONE;
      end
      S_DONE: if (drain == 2'd0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n       <= '0;
      rem     <= '0;
      len_q   <= '0;
      rma_q   <= '0;
      eid_q   <= '0;
      addr_q  <= '0;
      is_read <= 1'b0;
      pl_ptr  <= '0;
      drain   <= '0;
      len_out <= '0;
      drop_q  <= '0;
    end else begin
      if (accept) begin
        n       <= '0;
        len_q   <= bus.resp_payload_len;
        rma_q   <= bus.rma_id;
        eid_q   <= bus.element_id;
        addr_q  <= bus.mem_addr;
        is_read <= bus.send_read_resp;
        pl_ptr  <= ADDR_WIDTH'(bus.mem_addr);
        len_out <= (bus.send_read_resp && (frame_len > MIN_LEN)) ? frame_len : MIN_LEN;
      end else if (s0_valid) begin
        n <= n + 9'd1;
      end
      // remaining-byte down-counter is preloaded until the payload starts
      if (state == S_PAYLOAD) begin
        rem    <= rem - 8'd1;
        pl_ptr <= pl_ptr + 1'b1;
      end else begin
        rem <= len_q - 8'd1;
      end
      drain <= (state == S_DONE) ? drain - 2'd1 : 2'd2;
      if (drop_evt && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid   <= 1'b0;
      hdr_oe_q   <= 1'b0;
      hdr_addr_q <= '0;
      pl_oe_q    <= 1'b0;
      pl_addr_q  <= '0;
      s1_src     <= SRC_CONST;
      s1_const   <= '0;
      s1_n       <= '0;
      tx_we_q    <= 1'b0;
      tx_addr_q  <= '0;
      s2_src     <= SRC_CONST;
      s2_const   <= '0;
    end else begin
      s1_valid   <= s0_valid;
      hdr_oe_q   <= s0_hdr_oe;
      hdr_addr_q <= s0_hdr_addr;
      pl_oe_q    <= s0_pl_oe;
      pl_addr_q  <= s0_pl_addr;
      s1_src     <= s0_src;
      s1_const   <= s0_const;
      s1_n       <= n;
      tx_we_q    <= s1_valid;
      tx_addr_q  <= s1_valid ? TX_BASE + ADDR_WIDTH'(s1_n) : '0;
      s2_src     <= s1_valid ? s1_src : SRC_CONST;
      s2_const   <= s1_valid ? s1_const : 8'h00;
    end
  end

  // RAM read data lands in the same cycle as the matching write
  assign bus.tx_data  = (s2_src == SRC_HDR) ? bus.hdr_data :
                        (s2_src == SRC_PL)  ? bus.pl_data  : s2_const;
  assign bus.tx_we    = tx_we_q;
  assign bus.tx_addr  = tx_addr_q;
  assign bus.hdr_addr = hdr_addr_q;
  assign bus.hdr_oe   = hdr_oe_q;
  assign bus.pl_addr  = pl_addr_q;
  assign bus.pl_oe    = pl_oe_q;
  assign bus.tx_len   = len_out;
  assign bus.tx_start = (state == S_DONE) && (drain == 2'd0);
  assign bus.busy     = (state != S_IDLE);
  assign bus.drop_cnt = drop_q;
endmodule

// File: doc/ecpri_tx_resp.md
Name: ecpri_tx_resp

Overview:
Downstream stage of the eCPRI receive block. It consumes the send_read_resp / send_write_resp request and the response parameters, then builds a complete eCPRI Remote Memory Access (RMA) response frame, byte by byte, into the TX packet RAM, and pulses tx_start to the MAC transmit side. The frame is raw Ethernet (ethertype 0xAEFE): MAC-swapped 14-byte header copied from the RX header RAM, then a 16-byte eCPRI/RMA header, then read data from the payload RAM (read responses only), zero-padded to 60 bytes.

Parameters:
DATA_WIDTH, 8, RAM byte width
ADDR_WIDTH, 16, RAM address width
TX_BASE, 0, TX packet RAM address of frame byte 0
HDR_BASE, 0, RX header RAM address of received frame byte 0
MIN_FRAME, 60, minimum frame length in bytes, excluding FCS

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
send_read_resp  in  1  request to build a read response
send_write_resp  in  1  request to build a write response
resp_payload_len  in  8  L, RMA data length in bytes
rma_id  in  8  RMA ID echoed into response
element_id  in  16  element ID echoed into response
mem_addr  in  16  RMA address; also payload RAM start address for read data
hdr_addr  out  16  RX header RAM read address
hdr_oe  out  1  RX header RAM read enable
hdr_data  in  8  RX header RAM data, valid 1 cycle after address
pl_addr  out  16  payload RAM read address
pl_oe  out  1  payload RAM read enable
pl_data  in  8  payload RAM data, valid 1 cycle after address
tx_addr  out  16  TX packet RAM write address
tx_data  out  8  TX packet RAM write data
tx_we  out  1  TX packet RAM write enable
tx_len  out  16  frame length; valid while tx_start is high and held until the next accept
tx_start  out  1  one-cycle pulse when the frame is complete
busy  out  1  frame build in progress
drop_cnt  out  8  count of rejected requests; saturates at 255

Behaviour:
- Reset (reset=0, asynchronous): state goes to IDLE. All outputs are 0, including tx_len and drop_cnt.
- States: IDLE -> HDR -> ECPRI -> PAYLOAD (read responses only) -> PAD (only if needed) -> DONE -> IDLE.
- Accept (IDLE only): on a clock edge where either request is high, latch L, rma_id, element_id, mem_addr and the response type. Read wins if both are high; the lost write increments drop_cnt.
- Any request seen outside IDLE (including the DONE cycle) increments drop_cnt. Increment is saturating.
- Read pipeline: one address per cycle on hdr/pl; the matching tx_we write happens one cycle later.
- Timing:
  - First tx_we occurs 2 cycles after the accept edge.
  - Frame bytes are then written on contiguous cycles, one per cycle, to tx_addr = TX_BASE + n.
- Frame bytes:
  - Bytes 0-5 = header bytes 6-11 (source MAC becomes destination).
  - Bytes 6-11 = header bytes 0-5.
  - Bytes 12-13 = 0xAE, 0xFE, constants; no RAM read is required.
- eCPRI/RMA header, bytes 14-29:
  - 14 = 0x10; 15 = 0x04.
  - 16-17 = eCPRI payload size, big-endian: 12+L for read, 12 for write.
  - 18 = rma_id.
  - 19 = 0x01 for read response, 0x11 for write response.
  - 20-21 = element_id, big-endian.
  - 22-25 = 0x00; 26-27 = mem_addr, big-endian.
  - 28 = 0x00; 29 = L.
- Payload (read only): bytes 30..29+L come from pl_addr = mem_addr+i, i = 0..L-1. Address arithmetic wraps modulo 2^16. L=0 means no payload reads.
- Pad: if the byte count so far is below MIN_FRAME, write 0x00 up to byte MIN_FRAME-1.
- tx_len = max(30+L, 60) for read; 60 for write. Maximum is 285 (L=255).
- DONE: tx_start=1 for exactly one cycle, the cycle after the last tx_we. tx_we=0 in that cycle. State returns to IDLE next cycle.
- busy: high from the cycle after accept through the DONE cycle inclusive. A new accept is possible on the first IDLE edge.
- hdr_oe / pl_oe are high only in cycles that issue a read address.
- Reset mid-frame: frame is aborted; tx_start is not pulsed; drop_cnt is cleared. The next request after release is accepted normally.

Test Plan:
- Write resp: rma_id=0x5A, element_id=0x1234, mem_addr=0x0040, L=4 -> bytes 14-29 = 10 04 00 0C 5A 11 12 34 00 00 00 00 00 40 00 04; bytes 30-59 = 00; tx_len=60; no pl_oe; tx_start 62 cycles after accept.
- Read resp: L=40, mem_addr=0x0100, payload RAM[0x0100+i]=i -> bytes 16-17 = 00 34; byte 19 = 01; bytes 30-69 = 0x00..0x27; tx_len=70.
- MAC swap: header bytes 0-5 = AA.., 6-11 = BB.., 12-13 = 08 00 -> TX bytes 0-5 = BB.., 6-11 = AA.., 12-13 = AE FE.
- Arbitration/drop: read and write requests on the same edge -> read frame built, drop_cnt=1. Request held high for the whole frame -> drop_cnt counts each busy cycle. 300 dropped requests -> drop_cnt=255.
- Wrap/boundary: mem_addr=0xFFFE, L=4 -> pl_addr sequence FFFE, FFFF, 0000, 0001. L=255 -> tx_len=285, last write at tx_addr=TX_BASE+284. L=0 read -> tx_len=60.
- Reset asserted during payload -> all outputs 0 immediately; no tx_start. After release, a write request builds a correct 60-byte frame.
